// File: rtl/signed_div_8by4_if.sv
// Request/result bundle for the 8-by-4 signed divider.
// The master side issues operands and start; the slave side returns results and status.
interface signed_div_8by4_if;
   logic              start;
   logic signed [7:0] dividend;
   logic signed [3:0] divisor;
   logic signed [7:0] quotient;
   logic signed [3:0] remainder;
   logic              busy;
   logic              done;
   logic              div_by_zero;
   logic              overflow;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero, overflow
   );
endinterface

// File: rtl/signed_div_8by4.sv
// Sequential 8-by-4 signed divider: restoring division on magnitudes, one quotient
// bit per clock, sign fix-up at the end. Inverse datapath of the 4x4 Booth multiplier.
module signed_div_8by4 (
   input  logic            CLK,
   input  logic            RST,
   signed_div_8by4_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

   state_t              state_q, state_d;
   logic        [7:0]   dvd_q, dvd_d;
   logic        [3:0]   dvs_q, dvs_d;
   logic        [3:0]   part_q, part_d;
   logic        [3:0]   cnt_q, cnt_d;
   logic                sgnq_q, sgnq_d;
   logic                sgnr_q, sgnr_d;
   logic signed [7:0]   quot_q, quot_d;
   logic signed [3:0]   rem_q, rem_d;
   logic                done_q, done_d;
   logic                dbz_q, dbz_d;
   logic                ovf_q, ovf_d;
   logic        [4:0]   shifted;
   logic        [4:0]   trial;

   function automatic logic [7:0] abs8(input logic signed [7:0] v);
      return v[7] ? (~v + 8'd1) : v;
   endfunction

   function automatic logic [3:0] abs4(input logic signed [3:0] v);
      return v[3] ? (~v + 4'd1) : v;
   endfunction

   function automatic logic signed [7:0] apply_sign8(input logic neg, input logic [7:0] mag);
      return $signed(neg ? (~mag + 8'd1) : mag);
   endfunction

   function automatic logic signed [3:0] apply_sign4(input logic neg, input logic [3:0] mag);
      return $signed(neg ? (~mag + 4'd1) : mag);
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start && bus.divisor != 4'sd0) state_d = DIVIDE;
         DIVIDE:  if (cnt_q == 4'd7) state_d = FIXUP;
         FIXUP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != IDLE);
   end

   // Partial remainder stays below the divisor magnitude (max 8), so it fits in 4 bits;
   // the 5-bit trial sign tells whether the shifted partial reached the divisor.
   always_comb begin
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      part_d  = part_q;
      cnt_d   = cnt_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      shifted = {part_q, dvd_q[7]};
      trial   = shifted - {1'b0, dvs_q};
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == 4'sd0) begin
                  quot_d = '0;
                  rem_d  = '0;
                  dbz_d  = 1'b1;
                  ovf_d  = 1'b0;
                  done_d = 1'b1;
               end else begin
                  dvd_d  = abs8(bus.dividend);
                  dvs_d  = abs4(bus.divisor);
                  sgnq_d = bus.dividend[7] ^ bus.divisor[3];
                  sgnr_d = bus.dividend[7];
                  part_d = '0;
                  cnt_d  = '0;
               end
            end
         end
         DIVIDE: begin
            part_d = trial[4] ? shifted[3:0] : trial[3:0];
            dvd_d  = {dvd_q[6:0], ~trial[4]};
            cnt_d  = cnt_q + 4'd1;
         end
         FIXUP: begin
            quot_d = apply_sign8(sgnq_q, dvd_q);
            rem_d  = apply_sign4(sgnr_q, part_q);
            // A magnitude of 128 with a positive sign is the single unrepresentable case.
            ovf_d  = ~sgnq_q & (dvd_q == 8'h80);
            dbz_d  = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         part_q <= '0;
         cnt_q  <= '0;
         sgnq_q <= 1'b0;
         sgnr_q <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         part_q <= part_d;
         cnt_q  <= cnt_d;
         sgnq_q <= sgnq_d;
         sgnr_q <= sgnr_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         done_q <= done_d;
         dbz_q  <= dbz_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_signed_div_8by4.sv
// Scoreboard bench for signed_div_8by4: expectations come from integer division in SV
// (truncation toward zero, remainder sign of dividend) and are popped at each done.
module tb_signed_div_8by4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   signed_div_8by4_if bus ();

   signed_div_8by4 dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] q;
      logic [3:0] r;
      logic       dbz;
      logic       ovf;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t model(input logic signed [7:0] a, input logic signed [3:0] b);
      exp_t e;
      int   qi, ri;
      if (b == 4'sd0) begin
         e.q = 8'h00; e.r = 4'h0; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 0;
      end else begin
         qi    = int'(a) / int'(b);
         ri    = int'(a) % int'(b);
         e.q   = qi[7:0];
         e.r   = ri[3:0];
         e.dbz = 1'b0;
         e.ovf = (qi == 128);
         e.lat = 9;
      end
      return e;
   endfunction

   task automatic issue(input logic [7:0] a, input logic [3:0] b, output logic busy_e0);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      sb.push_back(model(a, b));
      @(posedge clk); #1;
      busy_e0   = bus.busy;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < bound) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b want all 0",
                  bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_signs;
      logic [7:0] as [6] = '{8'h64, 8'h9C, 8'h64, 8'hF9, 8'h7F, 8'h03};
      logic [3:0] bs [6] = '{4'h7,  4'h7,  4'h8,  4'h3,  4'hD, 4'h7};
      for (int i = 0; i < 6; i++) begin
         logic bz; int lat; exp_t e;
         issue(as[i], bs[i], bz);
         checks++;
         if (bz !== 1'b1) begin errors++; $display("FAIL signs_busy[%0d]: got %b want 1", i, bz); end
         wait_done(20, lat);
         e = sb.pop_front();
         checks++;
         if (lat != e.lat) begin errors++; $display("FAIL signs_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
         checks++;
         if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
            errors++;
            $display("FAIL signs_result[%0d] %h/%h: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     i, as[i], bs[i], bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, e.q, e.r, e.dbz, e.ovf);
         end
         @(posedge clk); #1;
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL signs_pulse[%0d]: got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_overflow;
      logic [7:0] as [4] = '{8'h80, 8'h80, 8'h80, 8'h7F};
      logic [3:0] bs [4] = '{4'hF,  4'h1,  4'h8,  4'h8};
      for (int i = 0; i < 4; i++) begin
         logic bz; int lat; exp_t e;
         issue(as[i], bs[i], bz);
         wait_done(20, lat);
         e = sb.pop_front();
         checks++;
         if (lat != 9) begin errors++; $display("FAIL ovf_latency[%0d]: got %0d want 9", i, lat); end
         checks++;
         if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
            errors++;
            $display("FAIL ovf_result[%0d] %h/%h: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     i, as[i], bs[i], bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, e.q, e.r, e.dbz, e.ovf);
         end
         if (i == 0) begin
            checks++;
            if (bus.quotient !== 8'h80 || bus.overflow !== 1'b1) begin
               errors++; $display("FAIL ovf_flag: got q=%h ovf=%b want q=80 ovf=1", bus.quotient, bus.overflow);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div_zero;
      logic bz; int lat; exp_t e;
      issue(8'h05, 4'h0, bz);
      checks++;
      if (bz !== 1'b0) begin errors++; $display("FAIL dbz_busy: got %b want 0", bz); end
      wait_done(20, lat);
      e = sb.pop_front();
      checks++;
      if (lat != 0) begin errors++; $display("FAIL dbz_latency: got %0d want 0", lat); end
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {8'h00, 4'h0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL dbz_result: got q=%h r=%h dbz=%b ovf=%b want q=00 r=0 dbz=1 ovf=0",
                  bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_by_zero !== e.dbz) begin
         errors++; $display("FAIL dbz_after: got done=%b busy=%b dbz=%b want 0 0 1", bus.done, bus.busy, bus.div_by_zero);
      end
      issue(8'h05, 4'h1, bz);
      wait_done(20, lat);
      e = sb.pop_front();
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {e.q, e.r, e.dbz, e.ovf} || lat != 9) begin
         errors++;
         $display("FAIL dbz_clear: got q=%h r=%h dbz=%b ovf=%b lat=%0d want q=%h r=%h dbz=%b ovf=%b lat=9",
                  bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, lat, e.q, e.r, e.dbz, e.ovf);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored;
      logic bz; int lat; int extra; exp_t e;
      issue(8'h64, 4'h7, bz);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 8'h11; bus.divisor = 4'h3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(20, lat);
      e = sb.pop_front();
      checks++;
      if (lat != 6) begin errors++; $display("FAIL ignore_latency: got %0d want 6 after E3", lat); end
      checks++;
      if ({bus.quotient, bus.remainder} !== {e.q, e.r} || bus.quotient !== 8'h0E || bus.remainder !== 4'h2) begin
         errors++; $display("FAIL ignore_result: got q=%h r=%h want q=0e r=2", bus.quotient, bus.remainder);
      end
      extra = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL ignore_single_done: got %0d extra dones want 0", extra); end
   endtask

   task automatic test_reset_abort;
      logic bz; int lat; int dones; exp_t e;
      issue(8'h11, 4'h3, bz);
      void'(sb.pop_back());
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 16'h0) begin
         errors++;
         $display("FAIL abort_clear: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b want all 0",
                  bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow);
      end
      dones = 0;
      repeat (3) begin @(posedge clk); #1; if (bus.done === 1'b1) dones++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) dones++; end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL abort_quiet: got %0d done/busy cycles want 0", dones); end
      issue(8'hF9, 4'h3, bz);
      wait_done(20, lat);
      e = sb.pop_front();
      checks++;
      if ({bus.quotient, bus.remainder} !== {e.q, e.r} || bus.quotient !== 8'hFE || bus.remainder !== 4'hF || lat != 9) begin
         errors++; $display("FAIL abort_recover: got q=%h r=%h lat=%0d want q=fe r=f lat=9", bus.quotient, bus.remainder, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [7:0] as [10];
      logic [3:0] bs [10];
      logic       bz;
      int         lat;
      exp_t       e;
      as[0] = 8'h80; bs[0] = 4'hF;
      as[1] = 8'h05; bs[1] = 4'h0;
      as[2] = 8'h9C; bs[2] = 4'h8;
      as[3] = 8'h64; bs[3] = 4'h7;
      for (int i = 4; i < 10; i++) begin
         as[i] = 8'($urandom);
         bs[i] = 4'($urandom_range(1, 15));
      end
      issue(as[0], bs[0], bz);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bz !== (bs[i] != 4'h0)) begin errors++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, bz, bs[i] != 4'h0); end
         wait_done(20, lat);
         e = sb.pop_front();
         checks++;
         if (lat != e.lat || {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
            errors++;
            $display("FAIL b2b_result[%0d] %h/%h: got q=%h r=%h dbz=%b ovf=%b lat=%0d want q=%h r=%h dbz=%b ovf=%b lat=%0d",
                     i, as[i], bs[i], bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, lat,
                     e.q, e.r, e.dbz, e.ovf, e.lat);
         end
         if (i < 9) issue(as[i+1], bs[i+1], bz);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_signs();
      test_overflow();
      test_div_zero();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
